// File: rtl/div.sv
`default_nettype none
// ============================================================================
//  Module   : div
//  Purpose  : Multi-cycle 32-bit restoring divider (signed/unsigned) for the
//             execute stage. One quotient bit is produced per clock. The
//             operation is held in END for as long as start_i stays high.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1   clock, all state updates on the rising edge
//    rst          in   1   synchronous active-high reset
//    signed_div_i in   1   1 = signed divide, 0 = unsigned divide
//    opdata1_i    in  32   dividend
//    opdata2_i    in  32   divisor
//    start_i      in   1   request, held high until the result is consumed
//    annul_i      in   1   cancel the operation in progress
//    result_o     out 64   {remainder, quotient}, registered
//    ready_o      out  1   result_o valid, registered
// ============================================================================
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;

    localparam logic [5:0] c_LAST_STEP = 6'd32;

    state_t      r_state,    w_state_nxt;
    logic [5:0]  r_cnt,      w_cnt_nxt;
    // [64:33] partial remainder, [32:1] dividend bits still to shift in
    // (progressively replaced by quotient bits at [31:0]).
    logic [64:0] r_dividend, w_dividend_nxt;
    // Divisor magnitude and sign corrections are captured at acceptance so
    // that later operand changes cannot disturb the running operation.
    logic [31:0] r_divisor,  w_divisor_nxt;
    logic        r_neg_quo,  w_neg_quo_nxt;
    logic        r_neg_rem,  w_neg_rem_nxt;
    logic [63:0] w_result_nxt;
    logic        w_ready_nxt;

    logic [31:0] w_op1_mag;
    logic [31:0] w_op2_mag;
    logic [32:0] w_diff;

    assign w_op1_mag = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign w_op2_mag = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // Trial subtraction; bit 32 set means the divisor did not fit.
    assign w_diff = {1'b0, r_dividend[63:32]} - {1'b0, r_divisor};

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_dividend_nxt = r_dividend;
        w_divisor_nxt  = r_divisor;
        w_neg_quo_nxt  = r_neg_quo;
        w_neg_rem_nxt  = r_neg_rem;
        w_result_nxt   = 64'h0;
        w_ready_nxt    = 1'b0;

        case (r_state)
            ST_FREE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'h0) begin
                        w_state_nxt = ST_BYZERO;
                    end else begin
                        w_state_nxt = ST_ON;
                        w_cnt_nxt   = 6'd0;
                    end
                    w_dividend_nxt = {32'h0, w_op1_mag, 1'b0};
                    w_divisor_nxt  = w_op2_mag;
                    w_neg_quo_nxt  = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                    w_neg_rem_nxt  = signed_div_i && opdata1_i[31];
                end
            end

            ST_BYZERO: begin
                if (annul_i) begin
                    w_state_nxt = ST_FREE;
                    w_cnt_nxt   = 6'd0;
                end else begin
                    w_dividend_nxt = 65'h0;
                    w_state_nxt    = ST_END;
                end
            end

            ST_ON: begin
                if (annul_i) begin
                    w_state_nxt = ST_FREE;
                    w_cnt_nxt   = 6'd0;
                end else if (r_cnt != c_LAST_STEP) begin
                    if (w_diff[32]) begin
                        w_dividend_nxt = r_dividend << 1;
                    end else begin
                        w_dividend_nxt = {w_diff[31:0], r_dividend[31:0], 1'b1};
                    end
                    w_cnt_nxt = r_cnt + 6'd1;
                end else begin
                    // Magnitudes are done; restore signs. Remainder follows
                    // the dividend, quotient follows the XOR of the signs.
                    if (r_neg_quo) begin
                        w_dividend_nxt[31:0] = ~r_dividend[31:0] + 32'd1;
                    end
                    if (r_neg_rem) begin
                        w_dividend_nxt[64:33] = ~r_dividend[64:33] + 32'd1;
                    end
                    w_state_nxt = ST_END;
                    w_cnt_nxt   = 6'd0;
                end
            end

            ST_END: begin
                if (start_i) begin
                    w_result_nxt = {r_dividend[64:33], r_dividend[31:0]};
                    w_ready_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_FREE;
                end
            end

            default: begin
                w_state_nxt = ST_FREE;
                w_cnt_nxt   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FREE;
            r_cnt      <= 6'd0;
            r_dividend <= 65'h0;
            r_divisor  <= 32'h0;
            r_neg_quo  <= 1'b0;
            r_neg_rem  <= 1'b0;
            result_o   <= 64'h0;
            ready_o    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dividend <= w_dividend_nxt;
            r_divisor  <= w_divisor_nxt;
            r_neg_quo  <= w_neg_quo_nxt;
            r_neg_rem  <= w_neg_rem_nxt;
            result_o   <= w_result_nxt;
            ready_o    <= w_ready_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div
//  Purpose  : Self-checking bench for div: directed vector table, random
//             operations against an arithmetic reference, and hand-written
//             annul / reset / END-hold sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_cmp  = 0;
    int n_fail = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: wide signed arithmetic, truncated to 32 bits.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) return 64'h0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Full transaction: accept, scramble operands, time ready, check result,
    // drop start and check return to idle.
    task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string name);
        int n;
        int lat;
        lat = (b == 32'h0) ? 2 : 34;
        @(negedge clk);
        rst          = 1'b0;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        n = 0;
        while (!ready_o && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, " latency"}, 64'(n), 64'(lat));
        chk({name, " result"}, result_o, exp);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({name, " idle"}, {63'h0, ready_o} | result_o, 64'h0);
    endtask

    initial begin
        int bad;
        int n;
        logic [31:0] a, b;
        bit sgn;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD};
        vecs[2] = '{1'b0, 32'hFFFFFFF9,   32'd2,        64'h00000001_7FFFFFFC};
        vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000};
        vecs[4] = '{1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF};
        vecs[5] = '{1'b1, 32'd1234,       32'd0,        64'h0};
        vecs[6] = '{1'b0, 32'hDEADBEEF,   32'd0,        64'h0};
        vecs[7] = '{1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
        vecs[8] = '{1'b0, 32'd0,          32'd5,        64'h0};
        vecs[9] = '{1'b1, 32'hFFFFFFFB,   32'hFFFFFFFB, 64'h00000000_00000001};

        rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        start_i = 1'b1; annul_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset state", {63'h0, ready_o} | result_o, 64'h0);

        // Directed table; the first entry also checks acceptance on the
        // first edge after reset release.
        for (int i = 0; i < 10; i++)
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        // Random operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 20));
                2: b = {$urandom} | 32'h8000_0000;
                default: b = $urandom;
            endcase
            run_op(sgn, a, b, ref_div(sgn, a, b), $sformatf("rand%0d", i));
        end

        // Annul at edge 10 of an ON operation.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        bad = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) bad++;
        end
        chk("annul quiet", 64'(bad), 64'h0);
        run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "after annul");

        // Annul while in BYZERO.
        @(negedge clk);
        opdata1_i = 32'd55; opdata2_i = 32'd0; start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        bad = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ready_o) bad++;
        end
        chk("annul byzero", 64'(bad), 64'h0);

        // Reset at edge 20 of an operation.
        @(negedge clk);
        opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        @(posedge clk);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid reset", {63'h0, ready_o} | result_o, 64'h0);
        run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "after reset");

        // END holds its result while start stays high; annul is ignored there.
        @(negedge clk);
        signed_div_i = 1'b1; opdata1_i = 32'hFFFFFF9C; opdata2_i = 32'd7; start_i = 1'b1;
        @(posedge clk);
        n = 0;
        while (!ready_o && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("hold first", result_o, ref_div(1'b1, 32'hFFFFFF9C, 32'd7));
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        chk("annul in end", {result_o[62:0], ready_o}, {ref_div(1'b1, 32'hFFFFFF9C, 32'd7) << 1} | 64'h1);
        @(negedge clk);
        annul_i = 1'b0;
        bad = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (!ready_o || result_o !== 64'hFFFFFFFE_FFFFFFF2) bad++;
        end
        chk("hold stable", 64'(bad), 64'h0);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("hold release", {63'h0, ready_o} | result_o, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
